cory_sink: RTL
==============

# cory_sink

Behavioral receive-end model for the codebase's valid/ready streams. It terminates a stream, throttles the upstream by deasserting ready for pseudo-random stall periods, and checks the received data against an incrementing reference. Testbenches place it at the output of a DUT to apply backpressure and count beats. It complements the source-side latency injectors, which delay valid.

## Interface
- N, 8: data width
- L, 8: stall-length width; maximum stall is 2^L-1 cycles
- I, 1: initial stall length after reset
- CHK, 1: 1 checks data against the expected sequence; 0 disables checking
- clk  in  1  clock
- reset  in  1  reset; one clock; reset is synchronous and active-high
- i_a_v  in  1  upstream valid
- i_a_d  in  N  upstream data
- o_a_r  out  1  ready to upstream, registered
- i_en  in  1  sink enable
- o_cnt  out  32  accepted-beat count, wraps
- o_last_d  out  N  data of the most recently accepted beat
- o_err  out  1  sticky data-mismatch flag
- o_err_cnt  out  16  mismatch count, saturates at 16'hFFFF

## Operation
- A beat is accepted when i_a_v & o_a_r are both high at a rising clk.
- States:
  - IDLE: o_a_r=0.
  - STALL: o_a_r=0; counter ctr counts cycles.
  - READY: o_a_r=1.
- Transitions:
  - IDLE → STALL if i_en and stall≠0; IDLE → READY if i_en and stall=0; otherwise stay in IDLE.
  - STALL: ctr increments each cycle. When ctr=stall-1, go to READY and clear ctr.
  - READY with an accepted beat: stall_next=stall*21+1, truncated to L bits. Go to STALL if stall_next≠0, otherwise stay in READY.
  - READY with no accepted beat: stay in READY.
- i_en low forces IDLE on the next cycle from any state and clears ctr.
  - stall, exp, and all counters and flags keep their values.
  - A beat accepted in the same cycle i_en falls is still counted and checked.
- Per accepted beat:
  - o_cnt += 1.
  - o_last_d ← i_a_d.
  - If CHK=1 and i_a_d≠exp: o_err ← 1 and o_err_cnt += 1 (saturating).
  - exp ← i_a_d+1 (mod 2^N), so the checker resyncs after a mismatch.
- i_a_d is ignored when no beat is accepted. Valid held high while ready is low is legal and is not an error.

## Timing
- Reset values:
  - state=IDLE, so o_a_r=0
  - stall=I, ctr=0, exp=0
  - o_cnt=0, o_last_d=0, o_err=0, o_err_cnt=0
- Reset asserted mid-operation returns every register to these values on the next edge, including from STALL or READY.
- o_a_r is a pure function of the state register; there is no combinational path from i_a_v.
- Stall length S after an accept means o_a_r is low for exactly S cycles, then high.
- S=0 gives back-to-back accepts at one beat per cycle.
- Statistics (o_cnt, o_last_d, o_err, o_err_cnt) update on the edge that accepts the beat and are visible in the following cycle.
- Wrap-around:
  - o_cnt wraps from 2^32-1 to 0.
  - exp wraps from 2^N-1 to 0.
  - The stall LCG wraps mod 2^L.

## Structure
- Package cory_sink_pkg holds:
  - the state typedef (IDLE, STALL, READY)
  - LCG constants: multiplier 21, increment 1
  - the error-count saturation constant
- Sub-module cory_lcg: an L-bit register with load, step-enable, and value output. It computes stall*21+1, is reused by other throttle models, and is reset to I.
- The top level holds the FSM, stall counter, expected-data register, and statistics.

## Test plan
- Reset, then i_en=1, I=1, upstream valid held high with data 0,1,2… → o_a_r low for 1 cycle after leaving IDLE. Beat 0 is accepted. o_a_r is then low 22 cycles, beat 1 is accepted, then low 207 cycles. o_cnt=2, o_err=0.
- I=0 with the same stimulus → after the first accept, stall_next=1, so o_a_r is low exactly 1 cycle before the next accept.
- Data sequence 0,1,5,6 with CHK=1 → o_err=1 after the third beat, o_err_cnt=1, no further errors. With CHK=0 the same sequence gives o_err=0.
- i_en dropped during a STALL of 22 cycles → IDLE next cycle and o_a_r stays 0. On re-enable, a fresh 22-cycle stall runs and o_cnt is unchanged.
- Reset asserted during READY with o_cnt=5 and o_err=1 → next cycle o_a_r=0, o_cnt=0, o_err=0, stall=I.
- Force o_err_cnt to 16'hFFFF and inject one more mismatch → it stays at 16'hFFFF.

Source files
------------

// File: rtl/cory_sink_pkg.sv
// Shared types and constants for the cory_sink receive-end stream model
// and the throttle LCG it shares with the other stall models.
package cory_sink_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        READY = 2'd2
    } state_t;

    localparam int unsigned LCG_MUL   = 21;
    localparam int unsigned LCG_INC   = 1;
    localparam int unsigned CNT_W     = 32;
    localparam int unsigned ERR_CNT_W = 16;

    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/cory_sink_if.sv
// Valid/ready stream seen from the sink: upstream drives valid/data,
// the sink drives ready.
interface cory_sink_if #(
    parameter int unsigned N = 8
);
    logic         i_a_v;
    logic [N-1:0] i_a_d;
    logic         o_a_r;

    modport master (output i_a_v, output i_a_d, input o_a_r);
    modport slave  (input i_a_v, input i_a_d, output o_a_r);
endinterface

// File: rtl/cory_lcg.sv
// L-bit linear congruential stall generator: value <- value*21 + 1 mod 2^L.
// Shared by the throttle models; o_nxt_c exposes the next value so callers can
// decide on it in the same cycle that they step.
module cory_lcg
    import cory_sink_pkg::*;
#(
    parameter int unsigned L = 8,
    parameter int unsigned I = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [L-1:0] i_load_val,
    input  logic         i_step,
    output logic [L-1:0] o_val,
    output logic [L-1:0] o_nxt_c
);

    logic [L-1:0] r_val;
    logic [L-1:0] w_nxt;

    assign w_nxt = L'(r_val * L'(LCG_MUL) + L'(LCG_INC));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_val <= L'(I);
        end else if (i_load) begin
            r_val <= i_load_val;
        end else if (i_step) begin
            r_val <= w_nxt;
        end
    end

    assign o_val   = r_val;
    assign o_nxt_c = w_nxt;

endmodule

// File: rtl/cory_sink.sv
// Stream terminator: throttles upstream with pseudo-random ready stalls,
// counts accepted beats and checks data against an incrementing reference.
module cory_sink
    import cory_sink_pkg::*;
#(
    parameter int unsigned N   = 8,
    parameter int unsigned L   = 8,
    parameter int unsigned I   = 1,
    parameter bit          CHK = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    cory_sink_if.slave           a,
    input  logic                 i_en,
    output logic [CNT_W-1:0]     o_cnt,
    output logic [N-1:0]         o_last_d,
    output logic                 o_err,
    output logic [ERR_CNT_W-1:0] o_err_cnt
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [L-1:0]         r_ctr;
    logic [L-1:0]         w_ctr_nxt;
    logic                 r_a_r;
    logic                 w_acc;
    logic                 w_step;
    logic                 w_mis;
    logic [L-1:0]         w_stall;
    logic [L-1:0]         w_stall_nxt;
    logic [N-1:0]         r_exp;
    logic [CNT_W-1:0]     r_cnt;
    logic [N-1:0]         r_last_d;
    logic                 r_err;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    cory_lcg #(
        .L (L),
        .I (I)
    ) u_lcg (
        .clk        (clk),
        .reset      (reset),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_step     (w_step),
        .o_val      (w_stall),
        .o_nxt_c    (w_stall_nxt)
    );

    assign w_acc = a.i_a_v & r_a_r;
    assign w_mis = CHK & (a.i_a_d != r_exp);

    always_comb begin
        w_state_nxt = r_state;
        w_ctr_nxt   = r_ctr;
        w_step      = 1'b0;
        if (!i_en) begin
            w_state_nxt = IDLE;
            w_ctr_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = (w_stall != '0) ? STALL : READY;
                end
                STALL: begin
                    if (r_ctr == w_stall - L'(1)) begin
                        w_state_nxt = READY;
                        w_ctr_nxt   = '0;
                    end else begin
                        w_ctr_nxt   = r_ctr + L'(1);
                    end
                end
                READY: begin
                    if (w_acc) begin
                        w_step = 1'b1;
                        if (w_stall_nxt != '0) begin
                            w_state_nxt = STALL;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // ready is a flop loaded from the next state, so it never sees valid
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ctr   <= '0;
            r_a_r   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ctr   <= w_ctr_nxt;
            r_a_r   <= (w_state_nxt == READY);
        end
    end

    // expected value follows the received data so one bad beat costs one error
    always_ff @(posedge clk) begin
        if (reset) begin
            r_exp     <= '0;
            r_cnt     <= '0;
            r_last_d  <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else if (w_acc) begin
            r_cnt    <= r_cnt + CNT_W'(1);
            r_last_d <= a.i_a_d;
            r_exp    <= a.i_a_d + N'(1);
            if (w_mis) begin
                r_err <= 1'b1;
                if (r_err_cnt != ERR_CNT_MAX) begin
                    r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
                end
            end
        end
    end

    assign a.o_a_r   = r_a_r;
    assign o_cnt     = r_cnt;
    assign o_last_d  = r_last_d;
    assign o_err     = r_err;
    assign o_err_cnt = r_err_cnt;

endmodule
